// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the x4-oversampling UART receiver:
//   - rx_state_t      : receiver FSM state encoding
//   - SAMPLES_PER_BIT : sample ticks per bit period
//   - MID_SAMPLE      : tick (after start detection) that confirms the start bit
//   - DEFAULT_DATA_BITS
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int unsigned SAMPLES_PER_BIT   = 4;
   localparam int unsigned MID_SAMPLE        = 2;
   localparam int unsigned DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Input conditioning for the UART receiver: a SYNC_STAGES-deep synchroniser on
// the asynchronous rx line (resets to idle-high) and a rising-edge detector on
// the baud generator's 4x square wave.
// Ports:
//   clock_in   in  system clock
//   reset_n    in  asynchronous active-low reset
//   baudrateX4 in  4x-baud toggling level (same clock domain)
//   rx         in  asynchronous serial line
//   rx_s       out synchronised rx
//   tick       out one-cycle sample strobe on each baudrateX4 rising edge
// -----------------------------------------------------------------------------
module uart_rx_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock_in,
   input  logic reset_n,
   input  logic baudrateX4,
   input  logic rx,
   output logic rx_s,
   output logic tick
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   baud_q;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
         baud_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         baud_q <= baudrateX4;
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];
   assign tick = baudrateX4 & ~baud_q;

endmodule

// File: rtl/uart_receiver_x4.sv
// -----------------------------------------------------------------------------
// uart_receiver_x4
// UART receiver (8N1, LSB first) sampling on a 4x-baud strobe. Received bytes
// are held in rx_data with a valid/ack handshake; frame and overrun errors are
// reported as one-cycle pulses.
// Build option: define UART_RX_PARITY_EN for 8E1 framing with parity_error;
// otherwise parity_error is tied low.
// Ports:
//   clock_in      in  system clock
//   reset_n       in  asynchronous active-low reset
//   baudrateX4    in  4x-baud toggling level from the baud generator
//   rx            in  serial line, idle high
//   rx_data       out last good byte
//   rx_valid      out rx_data holds an unacknowledged byte
//   rx_ack        in  consumer acknowledge, clears rx_valid
//   frame_error   out pulse: bad stop bit
//   overrun_error out pulse: good byte dropped because rx_valid was still set
//   parity_error  out pulse: parity mismatch (feature build only)
//   busy          out receiver not in IDLE
// -----------------------------------------------------------------------------
module uart_receiver_x4
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clock_in,
   input  logic                 reset_n,
   input  logic                 baudrateX4,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 frame_error,
   output logic                 overrun_error,
   output logic                 parity_error,
   output logic                 busy
);

   localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   // START confirms on the MID_SAMPLE-th tick after detection; the detection
   // tick itself leaves samp_cnt at 0, hence the -1.
   localparam logic [1:0]    SAMP_MID  = 2'(MID_SAMPLE - 1);
   localparam logic [1:0]    SAMP_LAST = 2'(SAMPLES_PER_BIT - 1);

   logic rx_s;
   logic tick;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .baudrateX4(baudrateX4),
      .rx        (rx),
      .rx_s      (rx_s),
      .tick      (tick)
   );

   rx_state_t            state_q, state_d;
   logic [1:0]           samp_q, samp_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_d;
   logic                 valid_d;
   logic                 fe_d, oe_d, pe_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
`endif

   always_comb begin
      state_d = state_q;
      samp_d  = samp_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = rx_data;
      valid_d = rx_valid;
      fe_d    = 1'b0;
      oe_d    = 1'b0;
      pe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
`endif

      if (rx_ack && rx_valid) begin
         valid_d = 1'b0;
      end

      if (tick) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  samp_d  = '0;
               end
            end
            START: begin
               samp_d = samp_q + 2'd1;
               if (samp_q == SAMP_MID) begin
                  if (rx_s) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     samp_d  = '0;
                     bit_d   = '0;
                  end
               end
            end
            DATA: begin
               samp_d = samp_q + 2'd1;
               if (samp_q == SAMP_LAST) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + BW'(1);
                  if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               samp_d = samp_q + 2'd1;
               if (samp_q == SAMP_LAST) begin
                  par_d   = (^shift_q) ^ rx_s;
                  state_d = STOP;
               end
            end
`endif
            STOP: begin
               samp_d = samp_q + 2'd1;
               if (samp_q == SAMP_LAST) begin
                  state_d = IDLE;
                  // Priority: frame > parity > load/overrun. A same-cycle ack
                  // frees the holding register, so the load wins over overrun.
                  if (!rx_s) begin
                     fe_d = 1'b1;
                  end
`ifdef UART_RX_PARITY_EN
                  else if (par_q) begin
                     pe_d = 1'b1;
                  end
`endif
                  else if (!rx_valid || rx_ack) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     oe_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         samp_q        <= '0;
         bit_q         <= '0;
         shift_q       <= '0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         state_q       <= state_d;
         samp_q        <= samp_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         rx_data       <= data_d;
         rx_valid      <= valid_d;
         frame_error   <= fe_d;
         overrun_error <= oe_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         par_q        <= 1'b0;
         parity_error <= 1'b0;
      end else begin
         par_q        <= par_d;
         parity_error <= pe_d;
      end
   end
`else
   assign parity_error = 1'b0;
`endif

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver_x4.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver_x4
// Directed bench for uart_receiver_x4. baudrateX4 toggles every 5 clocks
// (tick every 10 clocks, 40 clocks per bit). Frames start on a baudrateX4
// rising edge so the receiver timing is deterministic. Honours
// UART_RX_PARITY_EN for 8E1 framing.
// -----------------------------------------------------------------------------
module tb_uart_receiver_x4;

`ifdef UART_RX_PARITY_EN
   localparam int unsigned LAT       = 431;  // start-bit drive to rx_valid, clocks
   localparam int unsigned FRAME_CLK = 440;
`else
   localparam int unsigned LAT       = 391;
   localparam int unsigned FRAME_CLK = 400;
`endif

   logic       clock_in   = 1'b0;
   logic       reset_n    = 1'b0;
   logic       baudrateX4 = 1'b0;
   logic       rx         = 1'b1;
   logic       rx_ack     = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       overrun_error;
   logic       parity_error;
   logic       busy;

   int unsigned tests_run    = 0;
   int unsigned tests_failed = 0;
   int unsigned cyc          = 0;
   int unsigned fe_cnt       = 0;
   int unsigned oe_cnt       = 0;
   int unsigned pe_cnt       = 0;
   int unsigned valid_rise   = 0;
   int unsigned start_cyc    = 0;
   logic        valid_prev   = 1'b0;
   int unsigned fe0, oe0, pe0;

   uart_receiver_x4 #(
      .DATA_BITS  (8),
      .SYNC_STAGES(2)
   ) dut (
      .clock_in     (clock_in),
      .reset_n      (reset_n),
      .baudrateX4   (baudrateX4),
      .rx           (rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ack       (rx_ack),
      .frame_error  (frame_error),
      .overrun_error(overrun_error),
      .parity_error (parity_error),
      .busy         (busy)
   );

   always #5 clock_in = ~clock_in;

   always @(posedge clock_in) cyc <= cyc + 1;

   initial begin
      forever begin
         repeat (5) @(negedge clock_in);
         baudrateX4 = ~baudrateX4;
      end
   end

   // Counts high cycles of each pulse output, so a stretched pulse shows up.
   always @(negedge clock_in) begin
      if (frame_error)   fe_cnt++;
      if (overrun_error) oe_cnt++;
      if (parity_error)  pe_cnt++;
      if (rx_valid && !valid_prev) valid_rise = cyc;
      valid_prev = rx_valid;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clock_in);
   endtask

   task automatic snap();
      fe0 = fe_cnt;
      oe0 = oe_cnt;
      pe0 = pe_cnt;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
      @(posedge baudrateX4);
      start_cyc = cyc;
      rx = 1'b0;
      idle(40);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         idle(40);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^data) ^ par_flip;
      idle(40);
`else
      if (par_flip) $display("[TB] parity flip ignored in 8N1 build");
`endif
      rx = stop_bit;
      idle(40);
      rx = 1'b1;
   endtask

   task automatic ack_pulse();
      rx_ack = 1'b1;
      @(negedge clock_in);
      rx_ack = 1'b0;
   endtask

   initial begin
      // Reset state
      idle(3);
      check_eq("rst_data",  32'(rx_data), 32'h00);
      check_eq("rst_valid", 32'(rx_valid), 0);
      check_eq("rst_fe",    32'(frame_error), 0);
      check_eq("rst_oe",    32'(overrun_error), 0);
      check_eq("rst_pe",    32'(parity_error), 0);
      check_eq("rst_busy",  32'(busy), 0);
      reset_n = 1'b1;
      idle(10);

      // Good byte 0x41 with exact latency
      snap();
      send_frame(8'h41, 1'b1, 1'b0);
      check_eq("lat_41",   valid_rise - start_cyc, LAT);
      check_eq("data_41",  32'(rx_data), 32'h41);
      check_eq("valid_41", 32'(rx_valid), 1);
      check_eq("fe_41",    fe_cnt - fe0, 0);
      check_eq("oe_41",    oe_cnt - oe0, 0);
      ack_pulse();
      check_eq("ack_clr",  32'(rx_valid), 0);
      ack_pulse();
      check_eq("ack_idle_valid", 32'(rx_valid), 0);
      check_eq("ack_idle_data",  32'(rx_data), 32'h41);
      idle(20);

      // One-tick glitch on rx
      snap();
      @(posedge baudrateX4);
      rx = 1'b0;
      idle(10);
      rx = 1'b1;
      idle(5);
      check_eq("glitch_busy_hi", 32'(busy), 1);
      idle(20);
      check_eq("glitch_busy_lo", 32'(busy), 0);
      check_eq("glitch_valid",   32'(rx_valid), 0);
      check_eq("glitch_fe",      fe_cnt - fe0, 0);
      idle(20);

      // Bad stop bit
      snap();
      send_frame(8'h5A, 1'b0, 1'b0);
      idle(60);
      check_eq("fe_5a",    fe_cnt - fe0, 1);
      check_eq("valid_5a", 32'(rx_valid), 0);
      check_eq("data_5a",  32'(rx_data), 32'h41);
      check_eq("oe_5a",    oe_cnt - oe0, 0);

      // Overrun: 0x12 then 0x34 without ack
      snap();
      send_frame(8'h12, 1'b1, 1'b0);
      check_eq("data_12",  32'(rx_data), 32'h12);
      check_eq("valid_12", 32'(rx_valid), 1);
      idle(20);
      send_frame(8'h34, 1'b1, 1'b0);
      check_eq("oe_34",    oe_cnt - oe0, 1);
      check_eq("data_34",  32'(rx_data), 32'h12);
      check_eq("valid_34", 32'(rx_valid), 1);
      check_eq("fe_34",    fe_cnt - fe0, 0);
      ack_pulse();
      check_eq("ack_ovr",  32'(rx_valid), 0);
      idle(20);

      // Reset during data bit 3 of 0xFF, then 0x0F
      snap();
      @(posedge baudrateX4);
      rx = 1'b0;
      idle(40);
      rx = 1'b1;
      idle(40 * 3 + 20);
      check_eq("mid_busy",  32'(busy), 1);
      reset_n = 1'b0;
      #1;
      check_eq("mrst_busy",  32'(busy), 0);
      check_eq("mrst_data",  32'(rx_data), 32'h00);
      check_eq("mrst_valid", 32'(rx_valid), 0);
      @(negedge clock_in);
      reset_n = 1'b1;
      idle(40 * 5 + 20);
      send_frame(8'h0F, 1'b1, 1'b0);
      check_eq("data_0f",  32'(rx_data), 32'h0F);
      check_eq("valid_0f", 32'(rx_valid), 1);
      check_eq("fe_0f",    fe_cnt - fe0, 0);
      check_eq("oe_0f",    oe_cnt - oe0, 0);
      idle(20);

      // Load and ack in the same cycle: load wins, no overrun
      snap();
      fork
         send_frame(8'h77, 1'b1, 1'b0);
         begin
            @(posedge baudrateX4);
            idle(LAT - 1);
            ack_pulse();
         end
      join
      check_eq("la_data",  32'(rx_data), 32'h77);
      check_eq("la_valid", 32'(rx_valid), 1);
      check_eq("la_oe",    oe_cnt - oe0, 0);
      idle(20);

      // Break: line held low for two frame windows
      snap();
      @(posedge baudrateX4);
      rx = 1'b0;
      idle(2 * FRAME_CLK);
      rx = 1'b1;
      idle(100);
      check_eq("brk_fe",    fe_cnt - fe0, 2);
      check_eq("brk_oe",    oe_cnt - oe0, 0);
      check_eq("brk_data",  32'(rx_data), 32'h77);
      check_eq("brk_busy",  32'(busy), 0);
      ack_pulse();
      idle(20);

`ifdef UART_RX_PARITY_EN
      // Parity: 0x03 with parity bit 1 (bad), then 0 (good)
      snap();
      send_frame(8'h03, 1'b1, 1'b1);
      check_eq("par_bad_pe",    pe_cnt - pe0, 1);
      check_eq("par_bad_valid", 32'(rx_valid), 0);
      check_eq("par_bad_data",  32'(rx_data), 32'h77);
      idle(20);
      snap();
      send_frame(8'h03, 1'b1, 1'b0);
      check_eq("par_ok_pe",    pe_cnt - pe0, 0);
      check_eq("par_ok_data",  32'(rx_data), 32'h03);
      check_eq("par_ok_valid", 32'(rx_valid), 1);
`else
      check_eq("pe_never", pe_cnt, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
